uart_rx_port: RTL and testbench
===============================

# uart_rx_port

Memory-mapped UART receiver for the single-cycle MIPS core's peripheral bus.
- Deserialises the `rx` line (8N1, 16x oversampling) into a small FIFO.
- Answers CPU loads and stores to its three registers.
- Raises `irq` while data is pending.
- Sits inside the peripheral address space (`addr[30]=1`). The core gates `rd`/`wr` with that bit before they reach this block.

## Interface
- `CLK_FREQ`, default 100000000: system clock in Hz.
- `BAUD`, default 9600: line rate.
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.
- `clk` in 1: system clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rd` in 1: bus read strobe (already gated by `addr[30]`).
- `wr` in 1: bus write strobe (already gated by `addr[30]`).
- `addr` in 32: byte address. Only `addr[7:0]` is decoded.
- `wdata` in 32: write data.
- `rdata` out 32: combinational read data. 0 when `rd`=0 or the address is unmapped.
- `rx` in 1: asynchronous serial input; idle high.
- `irq` out 1: registered interrupt request.

## Operation
Registers:
- `0x18 RX_DATA` (read-only):
  - `[7:0]` = FIFO head, upper bits 0.
  - A read with FIFO non-empty pops the head on that clock edge.
  - Empty read returns 0, no pop.
- `0x1C RX_STAT`:
  - `[0]` non-empty, `[1]` full, `[2]` overrun (sticky), `[3]` frame error (sticky), `[7:4]` count.
  - Writing 1 to bit 2 or 3 clears that bit; other bits are read-only.
- `0x20 RX_CTRL` (read/write):
  - `[0]` enable, `[1]` irq enable. Other bits read 0.
  - Reset value 0.

Front end:
- `rx` passes through a 2-flop synchroniser; both flops reset to 1.
- Tick divider `TDIV = CLK_FREQ/(BAUD*16)`, integer-truncated, counting `0..TDIV-1`.
- The divider restarts at 0 whenever the FSM enters START.

Receive FSM (states IDLE, START, DATA, STOP):
- IDLE: a synchronised falling edge with enable=1 moves to START.
- START: after 8 ticks, sample. 0 → DATA with the bit counter at 0. 1 → IDLE (glitch, no flag).
- DATA: sample every 16 ticks, LSB first. After the 8th bit → STOP.
- STOP: after 16 ticks, sample, then return to IDLE in the next cycle.
  - Sample 1 → push the byte. If the FIFO is full, drop the byte and set overrun.
  - Sample 0 → discard the byte and set frame error.
- enable=0 forces IDLE immediately and abandons a partial frame. FIFO contents and flags are kept.

FIFO:
- Circular buffer with `DEPTH` entries and a count field.
- Push and pop in the same cycle: both succeed, including when full (pop first) and when holding exactly 1 entry. Count is unchanged.

Interrupt:
- `irq` is registered: `irq <= irq_en & non-empty`.

Reset values:
- `rdata`=0, `irq`=0, FIFO empty, flags 0, FSM IDLE, synchroniser 1.
- Reset mid-frame discards the frame.

## Timing
- `rdata` is combinational in the same cycle as `rd`, which the single-cycle core requires. The pop is visible from the next cycle.
- Push happens on the edge of the stop-bit sample. Non-empty/count update on that edge; `irq` rises one cycle later.
- From the `rx` falling edge to push: 2 (sync) + 8 + 16×8 + 16 ticks-worth of cycles, ±1 tick.
- A register write takes effect on the next edge.
- A write clearing a flag in the same cycle the FSM sets it: the set wins.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - An even-parity bit follows bit 7; STOP is entered after it.
  - Parity mismatch discards the byte and sets `RX_STAT[8]` (sticky, W1C).
- Macro undefined:
  - 8N1 framing only; `RX_STAT[8]` reads 0.

## Structure
- Shared package holds:
  - register offsets `RX_DATA_OFS`/`RX_STAT_OFS`/`RX_CTRL_OFS`;
  - FSM state encoding;
  - status bit positions.
- One sub-module, `uart_rx_fifo`: parameterised depth, push/pop/head/count/full/empty.
- Synchroniser, divider, FSM and register decode live in the top.

## Test plan
All scenarios use `CLK_FREQ=1600000`, `BAUD=10000`, so `TDIV=10` and 160 cycles per bit.
- **Single byte, irq.** Send `0xA5` with enable=1, irq_en=1 → `RX_STAT=0x11`, `irq`=1. Read `0x18` → `0x000000A5`; next cycle `RX_STAT=0x00`, `irq` falls one cycle later.
- **Overrun.** Send 5 bytes `0x01..0x05` with no reads → count 4, full=1, overrun=1. Reads return `0x01..0x04`, then 0.
- **Frame error and clear.** Send `0x3C` with stop bit 0 → FIFO empty, `RX_STAT[3]`=1. Write `0x8` to `0x1C` → bit clears.
- **Glitch rejection.** Drive a 40-cycle low pulse on `rx` → no push, no flags, FSM back in IDLE.
- **Simultaneous push and pop when full.** Read `0x18` on the push-edge cycle with the FIFO full → old head returned, count stays 4, no overrun.
- **Reset and disable mid-frame.** Assert `reset` in the middle of DATA → all outputs at reset values and the next frame is received correctly. Repeat with enable cleared mid-frame → partial frame discarded, FIFO unchanged.

Source files
------------

// File: rtl/uart_rx_port_pkg.sv
// Shared definitions for the memory-mapped UART receiver.
//   - register offsets (only addr[7:0] is decoded)
//   - receive FSM state encoding
//   - RX_STAT / RX_CTRL bit positions
//   - FRAME_BITS: 8 data bits, or 9 when UART_RX_PARITY_EN is defined
//     (the extra bit is the even-parity bit that follows bit 7)
package uart_rx_port_pkg;

    localparam logic [7:0] RX_DATA_OFS = 8'h18;
    localparam logic [7:0] RX_STAT_OFS = 8'h1C;
    localparam logic [7:0] RX_CTRL_OFS = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam int STAT_NONEMPTY  = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_FRAME     = 3;
    localparam int STAT_COUNT_LSB = 4;
    localparam int STAT_PARITY    = 8;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 9;
`else
    localparam int FRAME_BITS = 8;
`endif

endpackage

// File: rtl/uart_rx_port_if.sv
// Peripheral bus bundle between the MIPS core (master) and the UART
// receiver (slave).
//   rd, wr   : access strobes, already qualified by addr[30]
//   addr     : byte address
//   wdata    : store data
//   rdata    : combinational load data
//   irq      : registered interrupt request from the peripheral
interface uart_rx_port_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output rd, output wr, output addr, output wdata,
                    input rdata, input irq);
    modport slave  (input rd, input wr, input addr, input wdata,
                    output rdata, output irq);
endinterface

// File: rtl/uart_rx_fifo.sv
// Small circular receive FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write data_i (accepted when not full, or when popping)
//   pop_i      : drop the head (ignored when empty)
//   head_o     : current head, combinational
//   count_o    : number of entries held
//   full_o, empty_o
// A push and a pop in the same cycle both succeed, even when full: the
// head is consumed first so the slot being overwritten is the one leaving.
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [7:0]               data_i,
    input  logic                     pop_i,
    output logic [7:0]               head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_FULL);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_port.sv
// Memory-mapped UART receiver (8N1, 16x oversampling) for the MIPS
// peripheral bus.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   rx    : asynchronous serial input, idle high
//   bus   : slave side of uart_rx_port_if (rd/wr/addr/wdata/rdata/irq)
// Registers: 0x18 RX_DATA (read pops), 0x1C RX_STAT (W1C flags),
// 0x20 RX_CTRL (enable, irq enable).
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit after
// bit 7 and a sticky parity-error flag at RX_STAT[8].
module uart_rx_port
    import uart_rx_port_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600,
    parameter int DEPTH    = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx,
    uart_rx_port_if.slave  bus
);
    localparam int unsigned TDIV = CLK_FREQ / (BAUD * 16);
    localparam int          CW   = $clog2(DEPTH) + 1;

    // Synchroniser and edge detect; all idle-high after reset.
    logic [1:0] sync_q;
    logic       rx_prev_q;
    logic       rx_s;
    logic       rx_fall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], rx};
            rx_prev_q <= sync_q[1];
        end
    end
    assign rx_s    = sync_q[1];
    assign rx_fall = rx_prev_q & ~rx_s;

    // Register decode
    logic sel_data, sel_stat, sel_ctrl;
    logic wr_stat, wr_ctrl, pop;
    logic en_q, irq_en_q, ovr_q, ferr_q, irq_q;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;

    assign sel_data = (bus.addr[7:0] == RX_DATA_OFS);
    assign sel_stat = (bus.addr[7:0] == RX_STAT_OFS);
    assign sel_ctrl = (bus.addr[7:0] == RX_CTRL_OFS);
    assign wr_stat  = bus.wr & sel_stat;
    assign wr_ctrl  = bus.wr & sel_ctrl;
    assign pop      = bus.rd & sel_data & ~fifo_empty;

    // Receive FSM
    rx_state_e              state_q, state_d;
    logic [31:0]            div_q, div_d;
    logic [3:0]             tick_cnt_q, tick_cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic                   tick;
    logic                   push_req, frame_set, par_set;

    assign tick = (div_q == TDIV - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = tick ? '0 : div_q + 32'd1;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        push_req   = 1'b0;
        frame_set  = 1'b0;
        par_set    = 1'b0;
        if (!en_q) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_fall) begin
                        // Phase the divider to the start edge.
                        state_d    = ST_START;
                        div_d      = '0;
                        tick_cnt_d = '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                        if (tick_cnt_q == 4'd7) begin
                            // Mid start bit: from here every 16 ticks lands mid-bit.
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                            state_d    = rx_s ? ST_IDLE : ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                        if (tick_cnt_q == 4'd15) begin
                            shift_d   = {rx_s, shift_q[FRAME_BITS-1:1]};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'(FRAME_BITS - 1)) state_d = ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                        if (tick_cnt_q == 4'd15) begin
                            state_d = ST_IDLE;
                            if (!rx_s) frame_set = 1'b1;
`ifdef UART_RX_PARITY_EN
                            // Data plus even-parity bit must hold an even number of ones.
                            else if (^shift_q) par_set = 1'b1;
`endif
                            else push_req = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FIFO
    uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push_req),
        .data_i  (shift_q[7:0]),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A full FIFO still takes the byte if the CPU pops on the same edge.
    logic ovr_set;
    assign ovr_set = push_req & fifo_full & ~pop;

    // Control, sticky flags (set beats W1C clear), interrupt
    logic perr_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en_q     <= bus.wdata[CTRL_EN];
                irq_en_q <= bus.wdata[CTRL_IRQ_EN];
            end
            ovr_q  <= (ovr_q  & ~(wr_stat & bus.wdata[STAT_OVERRUN])) | ovr_set;
            ferr_q <= (ferr_q & ~(wr_stat & bus.wdata[STAT_FRAME]))   | frame_set;
`ifdef UART_RX_PARITY_EN
            perr_q <= (perr_q & ~(wr_stat & bus.wdata[STAT_PARITY]))  | par_set;
`else
            perr_q <= 1'b0;
`endif
            irq_q  <= irq_en_q & ~fifo_empty;
        end
    end

    // Read data. Count field is 4 bits wide; a DEPTH=16 FIFO that is full
    // shows count 0 there, with the full bit set.
    logic [8:0] stat_v;
    always_comb begin
        stat_v = '0;
        stat_v[STAT_NONEMPTY]          = ~fifo_empty;
        stat_v[STAT_FULL]              = fifo_full;
        stat_v[STAT_OVERRUN]           = ovr_q;
        stat_v[STAT_FRAME]             = ferr_q;
        stat_v[STAT_COUNT_LSB +: 4]    = 4'(fifo_count);
        stat_v[STAT_PARITY]            = perr_q;
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.rd) begin
            case (bus.addr[7:0])
                RX_DATA_OFS: bus.rdata = {24'h0, fifo_empty ? 8'h00 : fifo_head};
                RX_STAT_OFS: bus.rdata = {23'h0, stat_v};
                RX_CTRL_OFS: bus.rdata = {30'h0, irq_en_q, en_q};
                default:     bus.rdata = '0;
            endcase
        end
    end

    assign bus.irq = irq_q;

    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.addr[31:8], bus.wdata[31:4], par_set};
endmodule

// File: tb/tb_uart_rx_port.sv
// Self-checking bench for uart_rx_port. A queue-based model of the FIFO
// and flags predicts RX_STAT and RX_DATA from the bytes put on the line.
module tb_uart_rx_port;
    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 10000;
    localparam int DEPTH    = 4;
    localparam int BIT_CYC  = CLK_FREQ / BAUD;   // 160 cycles per bit
`ifdef UART_RX_PARITY_EN
    localparam int LINE_BITS = 11;
`else
    localparam int LINE_BITS = 10;
`endif
    // Rising edges from a start-edge driven after a falling edge to the
    // stop-bit sample: 2 sync + 1 edge detect, half a start bit (8 ticks of
    // 10 cycles), then one full bit for every remaining bit incl. stop.
    localparam int PUSH_EDGE = 3 + 80 + (LINE_BITS - 1) * BIT_CYC;

    localparam logic [31:0] A_DATA = 32'h4000_0018;
    localparam logic [31:0] A_STAT = 32'h4000_001C;
    localparam logic [31:0] A_CTRL = 32'h4000_0020;

    logic clk;
    logic reset;
    logic rx;
    uart_rx_port_if bus ();

    uart_rx_port #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model
    logic [7:0] mq[$];
    logic       m_ovr;
    logic       m_ferr;

    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (!stop)                 m_ferr = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(b);
        else                       m_ovr = 1'b1;
    endtask

    function automatic logic [31:0] model_stat();
        logic [31:0] s;
        s       = '0;
        s[0]    = (mq.size() != 0);
        s[1]    = (mq.size() == DEPTH);
        s[2]    = m_ovr;
        s[3]    = m_ferr;
        s[7:4]  = 4'(mq.size());
        return s;
    endfunction

    // Bus and line drivers
    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.rd   = 1'b1;
        bus.addr = a;
        #1 d = bus.rdata;
        @(negedge clk);
        bus.rd   = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.wr    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        @(negedge clk);
        bus.wr    = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = ^b;
        repeat (BIT_CYC) @(negedge clk);
`endif
        rx = stop;
        repeat (BIT_CYC) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    // Tests
    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", bus.irq); end
        n_cmp++;
        if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
        reset = 1'b1;
        bus_read(A_STAT, d);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL reset_stat: got %h want 0", d); end
        bus_read(A_CTRL, d);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL reset_ctrl: got %h want 0", d); end
        bus_read(A_DATA, d);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", d); end
        $display("test_reset done");
    endtask

    task automatic test_single_irq();
        logic [31:0] d;
        bus_write(A_CTRL, 32'h3);
        send_frame(8'hA5, 1'b1);
        model_frame(8'hA5, 1'b1);
        bus_read(A_STAT, d);
        n_cmp++;
        if (d !== 32'h11) begin n_err++; $display("FAIL single_stat: got %h want 00000011", d); end
        n_cmp++;
        if (bus.irq !== 1'b1) begin n_err++; $display("FAIL single_irq_high: got %b want 1", bus.irq); end
        bus_read(A_DATA, d);
        void'(mq.pop_front());
        n_cmp++;
        if (d !== 32'hA5) begin n_err++; $display("FAIL single_data: got %h want 000000a5", d); end
        n_cmp++;
        if (bus.irq !== 1'b1) begin n_err++; $display("FAIL single_irq_hold: got %b want 1", bus.irq); end
        bus_read(A_STAT, d);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL single_stat_after: got %h want 0", d); end
        n_cmp++;
        if (bus.irq !== 1'b0) begin n_err++; $display("FAIL single_irq_low: got %b want 0", bus.irq); end
        $display("test_single_irq done");
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] exp;
        for (int it = 0; it < 4; it++) begin
            int n;
            n = int'($urandom_range(1, 3));
            for (int k = 0; k < n; k++) begin
                logic [7:0] b;
                logic       stop;
                b    = 8'($urandom);
                stop = ($urandom_range(0, 4) != 0);
                send_frame(b, stop);
                model_frame(b, stop);
                $display("random frame byte=%h stop=%b", b, stop);
            end
            bus_read(A_STAT, d);
            exp = model_stat();
            n_cmp++;
            if (d !== exp) begin n_err++; $display("FAIL random_stat: got %h want %h", d, exp); end
            n_cmp++;
            if (bus.irq !== (mq.size() != 0)) begin
                n_err++; $display("FAIL random_irq: got %b want %b", bus.irq, (mq.size() != 0));
            end
            if (m_ferr) begin
                bus_write(A_STAT, 32'h8);
                m_ferr = 1'b0;
            end
            while (mq.size() != 0) begin
                exp = {24'h0, mq.pop_front()};
                bus_read(A_DATA, d);
                n_cmp++;
                if (d !== exp) begin n_err++; $display("FAIL random_data: got %h want %h", d, exp); end
            end
            bus_read(A_STAT, d);
            n_cmp++;
            if (d !== 32'h0) begin n_err++; $display("FAIL random_stat_drained: got %h want 0", d); end
        end
        $display("test_random done");
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        logic [31:0] exp;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            model_frame(8'(i), 1'b1);
        end
        bus_read(A_STAT, d);
        exp = model_stat();
        n_cmp++;
        if (d !== exp) begin n_err++; $display("FAIL overrun_stat: got %h want %h", d, exp); end
        for (int i = 0; i < 5; i++) begin
            exp = (mq.size() != 0) ? {24'h0, mq.pop_front()} : 32'h0;
            bus_read(A_DATA, d);
            n_cmp++;
            if (d !== exp) begin n_err++; $display("FAIL overrun_data%0d: got %h want %h", i, d, exp); end
        end
        bus_write(A_STAT, 32'h4);
        m_ovr = 1'b0;
        bus_read(A_STAT, d);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL overrun_clear: got %h want 0", d); end
        $display("test_overrun done");
    endtask

    task automatic test_frame_error();
        logic [31:0] d;
        logic [31:0] exp;
        send_frame(8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0);
        bus_read(A_STAT, d);
        exp = model_stat();
        n_cmp++;
        if (d !== exp) begin n_err++; $display("FAIL frame_stat: got %h want %h", d, exp); end
        bus_write(A_STAT, 32'h8);
        m_ferr = 1'b0;
        bus_read(A_STAT, d);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL frame_clear: got %h want 0", d); end
        $display("test_frame_error done");
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        logic [7:0]  b;
        @(negedge clk);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        bus_read(A_STAT, d);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL glitch_stat: got %h want 0", d); end
        b = 8'($urandom);
        send_frame(b, 1'b1);
        bus_read(A_DATA, d);
        n_cmp++;
        if (d !== {24'h0, b}) begin n_err++; $display("FAIL glitch_next_data: got %h want %h", d, b); end
        $display("test_glitch done");
    endtask

    task automatic test_full_pushpop();
        logic [31:0] d;
        logic [31:0] exp;
        logic [7:0]  b5;
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            send_frame(b, 1'b1);
            model_frame(b, 1'b1);
        end
        b5 = 8'($urandom);
        fork
            send_frame(b5, 1'b1);
            begin
                repeat (PUSH_EDGE - 1) @(negedge clk);
                bus_read(A_DATA, d);
            end
        join
        exp = {24'h0, mq.pop_front()};
        mq.push_back(b5);
        n_cmp++;
        if (d !== exp) begin n_err++; $display("FAIL pushpop_data: got %h want %h", d, exp); end
        bus_read(A_STAT, d);
        exp = model_stat();
        n_cmp++;
        if (d !== exp) begin n_err++; $display("FAIL pushpop_stat: got %h want %h", d, exp); end
        while (mq.size() != 0) begin
            exp = {24'h0, mq.pop_front()};
            bus_read(A_DATA, d);
            n_cmp++;
            if (d !== exp) begin n_err++; $display("FAIL pushpop_drain: got %h want %h", d, exp); end
        end
        $display("test_full_pushpop done");
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [7:0]  b;
        send_frame(8'h5A, 1'b1);
        fork
            send_frame(8'hC3, 1'b1);
            begin
                repeat (600) @(negedge clk);
                reset = 1'b0;
                repeat (3) @(negedge clk);
                n_cmp++;
                if (bus.irq !== 1'b0) begin n_err++; $display("FAIL midreset_irq: got %b want 0", bus.irq); end
                reset = 1'b1;
            end
        join
        mq.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        bus_read(A_STAT, d);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL midreset_stat: got %h want 0", d); end
        bus_read(A_CTRL, d);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL midreset_ctrl: got %h want 0", d); end
        bus_write(A_CTRL, 32'h3);
        b = 8'($urandom);
        send_frame(b, 1'b1);
        bus_read(A_DATA, d);
        n_cmp++;
        if (d !== {24'h0, b}) begin n_err++; $display("FAIL midreset_next: got %h want %h", d, b); end
        $display("test_reset_mid done");
    endtask

    task automatic test_disable_mid();
        logic [31:0] d;
        logic [31:0] exp;
        logic [7:0]  b1;
        logic [7:0]  b3;
        b1 = 8'($urandom);
        send_frame(b1, 1'b1);
        model_frame(b1, 1'b1);
        fork
            send_frame(8'h96, 1'b1);
            begin
                repeat (700) @(negedge clk);
                bus_write(A_CTRL, 32'h0);
            end
        join
        bus_read(A_STAT, d);
        exp = model_stat();
        n_cmp++;
        if (d !== exp) begin n_err++; $display("FAIL disable_stat: got %h want %h", d, exp); end
        bus_write(A_CTRL, 32'h3);
        bus_read(A_DATA, d);
        exp = {24'h0, mq.pop_front()};
        n_cmp++;
        if (d !== exp) begin n_err++; $display("FAIL disable_kept: got %h want %h", d, exp); end
        b3 = 8'($urandom);
        send_frame(b3, 1'b1);
        bus_read(A_DATA, d);
        n_cmp++;
        if (d !== {24'h0, b3}) begin n_err++; $display("FAIL disable_next: got %h want %h", d, b3); end
        bus_read(A_STAT, d);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL disable_stat_end: got %h want 0", d); end
        $display("test_disable_mid done");
    endtask

    initial begin
        reset     = 1'b0;
        rx        = 1'b1;
        bus.rd    = 1'b0;
        bus.wr    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        m_ovr     = 1'b0;
        m_ferr    = 1'b0;
        test_reset();
        test_single_irq();
        test_random();
        test_overrun();
        test_frame_error();
        test_glitch();
        test_full_pushpop();
        test_reset_mid();
        test_disable_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
